// File: rtl/immgen_pipe.sv
// rtl/immgen_pipe.sv - decode-stage immediate generator with a 2-entry valid/ready skid FIFO
// Output side is fed only from FIFO registers, so stalls never combine through to in_*.
module immgen_pipe #(
   parameter int XLEN  = 32,
   parameter int SEL_W = 3,
   parameter int TAG_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [24:0]      in_instr,
   input  logic [SEL_W-1:0] in_sel,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic             out_illegal,
   output logic [TAG_W-1:0] out_tag
);

   generate
      if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
         $error("immgen_pipe: XLEN must be 32 or 64");
      end
   endgenerate

   logic [31:7]     w_ins;
   logic [XLEN-1:0] w_imm;
   logic            w_illegal;
   logic            w_push;
   logic            w_pop;

   assign w_ins = in_instr;

   always_comb begin
      w_imm     = '0;
      w_illegal = 1'b0;
      case (in_sel)
         SEL_W'(0): w_imm = XLEN'($signed(w_ins[31:20]));
         SEL_W'(1): w_imm = XLEN'($signed({w_ins[31:25], w_ins[11:7]}));
         SEL_W'(2): w_imm = XLEN'($signed({w_ins[31], w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0}));
         SEL_W'(3): w_imm = XLEN'($signed({w_ins[31:12], 12'h000}));
         SEL_W'(4): w_imm = XLEN'($signed({w_ins[31], w_ins[19:12], w_ins[20], w_ins[30:21], 1'b0}));
         SEL_W'(5): w_imm = XLEN'(w_ins[19:15]);
         SEL_W'(6): begin
            // RV32 shift amounts are 5 bits; a set bit 25 is an illegal encoding
            if (XLEN == 64)
               w_imm = XLEN'(w_ins[25:20]);
            else if (w_ins[25])
               w_illegal = 1'b1;
            else
               w_imm = XLEN'(w_ins[24:20]);
         end
         default: w_illegal = 1'b1;
      endcase
   end

   logic [XLEN-1:0]  r_imm [2];
   logic [TAG_W-1:0] r_tag [2];
   logic [1:0]       r_ill;
   logic             r_wptr;
   logic             r_rptr;
   logic [1:0]       r_count;

   assign in_ready  = (r_count != 2'd2);
   assign out_valid = (r_count != 2'd0);
   assign w_push    = in_valid & in_ready;
   assign w_pop     = out_valid & out_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_imm[0] <= '0;
         r_imm[1] <= '0;
         r_tag[0] <= '0;
         r_tag[1] <= '0;
         r_ill    <= '0;
         r_wptr   <= 1'b0;
         r_rptr   <= 1'b0;
         r_count  <= 2'd0;
      end else if (flush) begin
         // Realign the write pointer to the head so stale out_* stay put
         r_count <= 2'd0;
         r_wptr  <= r_rptr;
      end else begin
         if (w_push) begin
            r_imm[r_wptr] <= w_imm;
            r_tag[r_wptr] <= in_tag;
            r_ill[r_wptr] <= w_illegal;
            r_wptr        <= ~r_wptr;
         end
         if (w_pop)
            r_rptr <= ~r_rptr;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign out_imm     = r_imm[r_rptr];
   assign out_tag     = r_tag[r_rptr];
   assign out_illegal = r_ill[r_rptr];

endmodule

// File: doc/immgen_pipe.md
Name: immgen_pipe

Overview:
- Registered, parametrised immediate generator for the decode stage.
- Extracts and sign- or zero-extends the immediate for a selected instruction format at configurable XLEN.
- Adds CSR-zimm and shift-amount formats and flags illegal selects.
- Passes results through a 2-entry skid buffer with valid/ready handshakes on both sides, so decode can stall without losing instructions. Sits between the fetch/decode register and the operand-select mux.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- SEL_W, 3, width of imm_sel.
- TAG_W, 32, width of the sideband tag (PC) carried with each entry.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous; discards all buffered entries.
- in_valid  in  1  upstream presents an instruction.
- in_ready  out  1  block can accept this cycle.
- in_instr  in  25  instruction bits [31:7].
- in_sel  in  SEL_W  format select.
- in_tag  in  TAG_W  sideband, returned unchanged.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts head.
- out_imm  out  XLEN  extended immediate.
- out_illegal  out  1  select or field illegal for this XLEN.
- out_tag  out  TAG_W  tag of head entry.

Behaviour:
- Format encoding of in_sel:
  - 000 I: sign-extend instr[31:20].
  - 001 S: sign-extend {instr[31:25], instr[11:7]}.
  - 010 B: sign-extend {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - 011 U: {instr[31:12], 12'b0}, sign-extended from bit 31 to XLEN.
  - 100 J: sign-extend {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - 101 ZIMM: zero-extend instr[19:15].
  - 110 SHAMT: zero-extend instr[24:20] (XLEN=32) or instr[25:20] (XLEN=64).
  - 111: illegal.
- Illegal entries: out_illegal=1 and out_imm=0. This applies to sel 111, and to SHAMT with XLEN=32 and instr[25]=1.
- Extension is computed combinationally from the in_* signals. The result is written into the buffer on accept. No combinational path from in_* to out_*.
- Buffer: 2-entry FIFO with occupancy count 0..2.
  - in_ready = (count<2); it depends only on registered state.
  - out_valid = (count>0); out_* show the oldest entry.
  - Push when in_valid & in_ready. Pop when out_valid & out_ready.
- Latency: an entry accepted at edge N is visible on out_* after edge N (1 cycle) if the buffer was empty. Otherwise it is visible after all older entries pop. Order is strictly FIFO.
- Count=0: a pop is impossible and a push gives count 1.
- Count=1: push with pop in the same cycle leaves count 1; the new entry becomes head on the next cycle.
- Count=2: in_ready=0, so in_valid is ignored (no push, no overwrite). A pop gives count 1, and in_ready rises on the next cycle.
- out_* hold stable while out_valid & !out_ready.
- flush=1: count goes to 0 at the edge. It overrides push and pop in the same cycle, and the flushed-cycle input is dropped. out_valid=0 on the next cycle. out_imm, out_tag and out_illegal keep their last values (don't-care while invalid).
- Reset asserted at any time, including mid-transfer, immediately gives:
  - count=0, out_valid=0;
  - out_imm=0, out_tag=0, out_illegal=0;
  - FIFO pointers=0;
  - in_ready=1.
- Deassertion is synchronised outside this block. The first accept can occur at the first rising edge with reset low.
- Behaviour with XLEN outside {32,64}: elaboration error.

Test Plan:
- XLEN=32: push instr 0xFFF00093 with sel 000 and tag 0x100, out_ready=1 → one cycle later out_valid=1, out_imm=0xFFFFFFFF, out_tag=0x100, out_illegal=0.
- Back-to-back pushes of S 0x0020A423 (sel 001), J 0x800000EF (sel 100) and ZIMM 0x000F8073 (sel 101), out_ready=1 → outputs in order 0x00000008, 0xFFF00000, 0x0000001F, with in_ready held at 1 throughout.
- Stall: out_ready=0 and 3 pushes → after 2 accepts in_ready=0, the 3rd is held upstream and out_* are stable. Raising out_ready gives 3 outputs in order with none lost or duplicated.
- XLEN=64: U 0x80000037 (sel 011) → out_imm=0xFFFFFFFF80000000. SHAMT with instr[25:20]=6'b111111 → out_imm=63, out_illegal=0.
- Illegal cases: sel 111 → out_illegal=1, out_imm=0. XLEN=32 with SHAMT and instr[25]=1 → out_illegal=1.
- Flush with count=2 plus a concurrent push → next cycle out_valid=0 and in_ready=1. Then assert reset asynchronously mid-stall → out_valid and out_imm go to 0 before the next clock edge.
